// File: rtl/ls_exec_ctrl.sv
// rtl/ls_exec_ctrl.sv - load/store execution sequencer: LSQ issue -> PRF read -> data memory -> LS result bus
// One op in flight; a flushed memory access is drained so the memory handshake is never abandoned mid-request.
module ls_exec_ctrl #(
  parameter int DW      = 32,
  parameter int AW      = 16,
  parameter int PW      = 5,
  parameter int TW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          valid_op_awake,
  input  logic          mode_awake,
  input  logic [PW-1:0] Px_awake,
  input  logic [AW-1:0] Addr_awake,
  input  logic [TW-1:0] tag_ROB_awake,
  output logic          freeze_back,
  output logic [PW-1:0] prf_raddr,
  input  logic [DW-1:0] prf_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          valid_Result_ls,
  output logic          mode_ls,
  output logic [PW-1:0] Pw_Result_ls,
  output logic [TW-1:0] tag_ROB_Result_ls,
  output logic [DW-1:0] Data_Result_ls,
  output logic          err_ls
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          mode_q;
  logic [PW-1:0] px_q;
  logic [AW-1:0] addr_q;
  logic [TW-1:0] tag_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] data_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic capture;
  logic expire;
  logic req_phase;

  assign capture   = (state == S_IDLE) && valid_op_awake && !flush;
  assign expire    = !mem_ack && (cnt_q == CNT_LAST);
  assign req_phase = (state == S_MEM) || (state == S_DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (capture) state_nxt = mode_awake ? S_MEM : S_RD;
      S_RD:    state_nxt = flush ? S_IDLE : S_MEM;
      S_MEM: begin
        if (mem_ack)     state_nxt = flush ? S_IDLE : S_WB;
        else if (flush)  state_nxt = S_DRAIN;
        else if (expire) state_nxt = S_WB;
      end
      S_WB:    state_nxt = S_IDLE;
      S_DRAIN: if (mem_ack || expire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    freeze_back       = (state != S_IDLE) || valid_op_awake;
    prf_raddr         = '0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    valid_Result_ls   = 1'b0;
    mode_ls           = 1'b0;
    Pw_Result_ls      = '0;
    tag_ROB_Result_ls = '0;
    Data_Result_ls    = '0;
    err_ls            = 1'b0;
    if (state == S_RD) prf_raddr = px_q;
    if (req_phase) begin
      mem_req   = 1'b1;
      mem_we    = ~mode_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    // A flush in the broadcast cycle squashes the result entirely.
    if ((state == S_WB) && !flush) begin
      valid_Result_ls   = 1'b1;
      mode_ls           = mode_q;
      Pw_Result_ls      = mode_q ? px_q : '0;
      tag_ROB_Result_ls = tag_q;
      Data_Result_ls    = data_q;
      err_ls            = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      px_q    <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (capture) begin
            mode_q  <= mode_awake;
            px_q    <= Px_awake;
            addr_q  <= Addr_awake;
            tag_q   <= tag_ROB_awake;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_RD: begin
          wdata_q <= prf_rdata;
          cnt_q   <= '0;
        end
        S_MEM, S_DRAIN: begin
          // Saturate so a flush landing on the last watchdog cycle cannot wrap the count.
          if (!mem_ack && (cnt_q != CNT_LAST)) cnt_q <= cnt_q + CW'(1);
          if (state == S_MEM) begin
            if (mem_ack) begin
              data_q <= mode_q ? mem_rdata : '0;
              err_q  <= 1'b0;
            end else if (expire) begin
              data_q <= '0;
              err_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
